// File: rtl/bf_sram_arbiter_if.sv
// Bundle of the requester A/B handshakes and the shared SRAM read/write port.
// The arbiter connects through the slave modport. The engines and the SRAM
// controller side connect through the master modport.
interface bf_sram_arbiter_if #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 72
) ();
  // requester A
  logic                       a_rd_req;
  logic [SRAM_ADDR_WIDTH-1:0] a_rd_addr;
  logic                       a_rd_ack;
  logic                       a_rd_vld;
  logic [SRAM_DATA_WIDTH-1:0] a_rd_data;
  logic                       a_wr_req;
  logic [SRAM_ADDR_WIDTH-1:0] a_wr_addr;
  logic [SRAM_DATA_WIDTH-1:0] a_wr_data;
  logic                       a_wr_ack;
  // requester B
  logic                       b_rd_req;
  logic [SRAM_ADDR_WIDTH-1:0] b_rd_addr;
  logic                       b_rd_ack;
  logic                       b_rd_vld;
  logic [SRAM_DATA_WIDTH-1:0] b_rd_data;
  logic                       b_wr_req;
  logic [SRAM_ADDR_WIDTH-1:0] b_wr_addr;
  logic [SRAM_DATA_WIDTH-1:0] b_wr_data;
  logic                       b_wr_ack;
  // shared SRAM port
  logic                       rd_0_req;
  logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr;
  logic                       rd_0_ack;
  logic                       rd_0_vld;
  logic [SRAM_DATA_WIDTH-1:0] rd_0_data;
  logic                       wr_0_req;
  logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr;
  logic [SRAM_DATA_WIDTH-1:0] wr_0_data;
  logic                       wr_0_ack;

  modport slave (
    input  a_rd_req, a_rd_addr, a_wr_req, a_wr_addr, a_wr_data,
    input  b_rd_req, b_rd_addr, b_wr_req, b_wr_addr, b_wr_data,
    output a_rd_ack, a_rd_vld, a_rd_data, a_wr_ack,
    output b_rd_ack, b_rd_vld, b_rd_data, b_wr_ack,
    output rd_0_req, rd_0_addr, wr_0_req, wr_0_addr, wr_0_data,
    input  rd_0_ack, rd_0_vld, rd_0_data, wr_0_ack
  );

  modport master (
    output a_rd_req, a_rd_addr, a_wr_req, a_wr_addr, a_wr_data,
    output b_rd_req, b_rd_addr, b_wr_req, b_wr_addr, b_wr_data,
    input  a_rd_ack, a_rd_vld, a_rd_data, a_wr_ack,
    input  b_rd_ack, b_rd_vld, b_rd_data, b_wr_ack,
    input  rd_0_req, rd_0_addr, wr_0_req, wr_0_addr, wr_0_data,
    output rd_0_ack, rd_0_vld, rd_0_data, wr_0_ack
  );
endinterface

// File: rtl/bf_sram_arbiter.sv
// Shares one SRAM read port and one write port between the aging engine (A)
// and the lookup/update engine (B). The read and write channels are
// arbitrated independently. Read returns come back in issue order, and a
// tag FIFO of owner bits steers each return to the requester that issued it.
module bf_sram_arbiter #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 72,
  parameter int TAG_DEPTH_BITS  = 3,
  parameter int PRIO_MODE       = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  bf_sram_arbiter_if.slave        bus,
  output logic [TAG_DEPTH_BITS:0] rd_outstanding,
  output logic                    rd_err
);

  localparam int TAG_DEPTH = 1 << TAG_DEPTH_BITS;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} ch_state_t;

  ch_state_t                  rd_state_q, rd_state_d;
  ch_state_t                  wr_state_q, wr_state_d;
  logic                       rd_grant, rd_win_b, rd_done, rd_owner_b, rd_pri_b;
  logic                       wr_grant, wr_win_b, wr_done, wr_owner_b, wr_pri_b;
  logic [SRAM_ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
  logic [SRAM_DATA_WIDTH-1:0] wr_data_q;

  logic [TAG_DEPTH-1:0]       tag_mem;
  logic [TAG_DEPTH_BITS-1:0]  tag_wptr, tag_rptr;
  logic                       tag_push, tag_pop, tag_full, tag_empty, tag_head_b;

  // The pointer names the side that is favoured on the next contested grant.
  // PRIO_MODE=1 ignores the pointer, and B always wins.
  function automatic logic pick_b(input logic req_a, input logic req_b, input logic pri_b);
    if (PRIO_MODE == 1) return req_b;
    return req_b && (!req_a || pri_b);
  endfunction

  assign tag_full   = (rd_outstanding == (TAG_DEPTH_BITS+1)'(TAG_DEPTH));
  assign tag_empty  = (rd_outstanding == '0);
  assign tag_push   = rd_done;
  assign tag_pop    = bus.rd_0_vld && !tag_empty;
  assign tag_head_b = tag_mem[tag_rptr];

  // Read channel next state: grant from IDLE, and release on the SRAM ack.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant   = 1'b0;
    rd_win_b   = 1'b0;
    rd_done    = 1'b0;
    case (rd_state_q)
      IDLE: if ((bus.a_rd_req || bus.b_rd_req) && !tag_full) begin
        rd_grant   = 1'b1;
        rd_win_b   = pick_b(bus.a_rd_req, bus.b_rd_req, rd_pri_b);
        rd_state_d = BUSY;
      end
      BUSY: if (bus.rd_0_ack) begin
        rd_done    = 1'b1;
        rd_state_d = IDLE;
      end
      default: rd_state_d = IDLE;
    endcase
  end

  // Read channel state, latched owner/address and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q <= IDLE;
      rd_owner_b <= 1'b0;
      rd_addr_q  <= '0;
      rd_pri_b   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      if (rd_grant) begin
        rd_owner_b <= rd_win_b;
        rd_addr_q  <= rd_win_b ? bus.b_rd_addr : bus.a_rd_addr;
      end
      if (rd_done) rd_pri_b <= !rd_owner_b;
    end
  end

  // Write channel next state: same IDLE/BUSY scheme, with no tags.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant   = 1'b0;
    wr_win_b   = 1'b0;
    wr_done    = 1'b0;
    case (wr_state_q)
      IDLE: if (bus.a_wr_req || bus.b_wr_req) begin
        wr_grant   = 1'b1;
        wr_win_b   = pick_b(bus.a_wr_req, bus.b_wr_req, wr_pri_b);
        wr_state_d = BUSY;
      end
      BUSY: if (bus.wr_0_ack) begin
        wr_done    = 1'b1;
        wr_state_d = IDLE;
      end
      default: wr_state_d = IDLE;
    endcase
  end

  // Write channel state, latched owner/address/data and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state_q <= IDLE;
      wr_owner_b <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_pri_b   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      if (wr_grant) begin
        wr_owner_b <= wr_win_b;
        wr_addr_q  <= wr_win_b ? bus.b_wr_addr : bus.a_wr_addr;
        wr_data_q  <= wr_win_b ? bus.b_wr_data : bus.a_wr_data;
      end
      if (wr_done) wr_pri_b <= !wr_owner_b;
    end
  end

  // Owner tag FIFO, outstanding-read count and sticky error for orphan returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_mem        <= '0;
      tag_wptr       <= '0;
      tag_rptr       <= '0;
      rd_outstanding <= '0;
      rd_err         <= 1'b0;
    end else begin
      if (tag_push) begin
        tag_mem[tag_wptr] <= rd_owner_b;
        tag_wptr          <= tag_wptr + 1'b1;
      end
      if (tag_pop) tag_rptr <= tag_rptr + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
        2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
        default: rd_outstanding <= rd_outstanding;
      endcase
      if (bus.rd_0_vld && tag_empty) rd_err <= 1'b1;
    end
  end

  assign bus.rd_0_req  = (rd_state_q == BUSY);
  assign bus.rd_0_addr = rd_addr_q;
  assign bus.wr_0_req  = (wr_state_q == BUSY);
  assign bus.wr_0_addr = wr_addr_q;
  assign bus.wr_0_data = wr_data_q;

  assign bus.a_rd_ack  = rd_done && !rd_owner_b;
  assign bus.b_rd_ack  = rd_done &&  rd_owner_b;
  assign bus.a_wr_ack  = wr_done && !wr_owner_b;
  assign bus.b_wr_ack  = wr_done &&  wr_owner_b;

  assign bus.a_rd_vld  = tag_pop && !tag_head_b;
  assign bus.b_rd_vld  = tag_pop &&  tag_head_b;
  assign bus.a_rd_data = bus.rd_0_data;
  assign bus.b_rd_data = bus.rd_0_data;

endmodule

// File: tb/tb_bf_sram_arbiter.sv
// Directed bench for bf_sram_arbiter. dut0 runs round-robin and dut1 runs
// B-priority. Inputs are driven on the falling edge, and outputs are sampled
// 1 ns later.
module tb_bf_sram_arbiter;
  localparam int AW = 19;
  localparam int DW = 72;
  localparam int TB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [TB:0]   out0, out1;
  logic          err0, err1;
  int            n_cmp, n_fail;

  always #5 clk = ~clk;

  bf_sram_arbiter_if #(.SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW)) bus0 ();
  bf_sram_arbiter_if #(.SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW)) bus1 ();

  bf_sram_arbiter #(.SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .TAG_DEPTH_BITS(TB), .PRIO_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .rd_outstanding(out0), .rd_err(err0));
  bf_sram_arbiter #(.SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .TAG_DEPTH_BITS(TB), .PRIO_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .rd_outstanding(out1), .rd_err(err1));

  task automatic clear_inputs();
    bus0.a_rd_req = 0; bus0.a_rd_addr = '0; bus0.a_wr_req = 0; bus0.a_wr_addr = '0; bus0.a_wr_data = '0;
    bus0.b_rd_req = 0; bus0.b_rd_addr = '0; bus0.b_wr_req = 0; bus0.b_wr_addr = '0; bus0.b_wr_data = '0;
    bus0.rd_0_ack = 0; bus0.rd_0_vld = 0; bus0.rd_0_data = '0; bus0.wr_0_ack = 0;
    bus1.a_rd_req = 0; bus1.a_rd_addr = '0; bus1.a_wr_req = 0; bus1.a_wr_addr = '0; bus1.a_wr_data = '0;
    bus1.b_rd_req = 0; bus1.b_rd_addr = '0; bus1.b_wr_req = 0; bus1.b_wr_addr = '0; bus1.b_wr_data = '0;
    bus1.rd_0_ack = 0; bus1.rd_0_vld = 0; bus1.rd_0_data = '0; bus1.wr_0_ack = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (bus0.rd_0_req !== 1'b0) begin n_fail++; $display("FAIL rst_rd_req: got %0h want 0", bus0.rd_0_req); end
    n_cmp++; if (bus0.wr_0_req !== 1'b0) begin n_fail++; $display("FAIL rst_wr_req: got %0h want 0", bus0.wr_0_req); end
    n_cmp++; if (out0 !== 4'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", out0); end
    n_cmp++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0h want 0", err0); end
    n_cmp++; if (bus0.a_rd_vld !== 1'b0 || bus0.b_rd_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %0h%0h want 00", bus0.a_rd_vld, bus0.b_rd_vld); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk); bus0.a_rd_addr = 19'h00010; bus0.a_rd_req = 1; #1;
    n_cmp++; if (bus0.rd_0_req !== 1'b0) begin n_fail++; $display("FAIL sr_req_pre: got %0h want 0", bus0.rd_0_req); end
    @(negedge clk); #1;
    n_cmp++; if (bus0.rd_0_req !== 1'b1) begin n_fail++; $display("FAIL sr_req: got %0h want 1", bus0.rd_0_req); end
    n_cmp++; if (bus0.rd_0_addr !== 19'h00010) begin n_fail++; $display("FAIL sr_addr: got %0h want 10", bus0.rd_0_addr); end
    @(negedge clk); #1;
    n_cmp++; if (bus0.a_rd_ack !== 1'b0) begin n_fail++; $display("FAIL sr_ack_early: got %0h want 0", bus0.a_rd_ack); end
    @(negedge clk); bus0.rd_0_ack = 1; #1;
    n_cmp++; if (bus0.a_rd_ack !== 1'b1 || bus0.b_rd_ack !== 1'b0) begin n_fail++; $display("FAIL sr_ack: got a=%0h b=%0h want a=1 b=0", bus0.a_rd_ack, bus0.b_rd_ack); end
    @(negedge clk); bus0.rd_0_ack = 0; bus0.a_rd_req = 0; #1;
    n_cmp++; if (bus0.rd_0_req !== 1'b0) begin n_fail++; $display("FAIL sr_req_drop: got %0h want 0", bus0.rd_0_req); end
    n_cmp++; if (out0 !== 4'd1) begin n_fail++; $display("FAIL sr_out1: got %0d want 1", out0); end
    @(negedge clk); bus0.rd_0_vld = 1; bus0.rd_0_data = 72'h1234; #1;
    n_cmp++; if (bus0.a_rd_vld !== 1'b1 || bus0.b_rd_vld !== 1'b0) begin n_fail++; $display("FAIL sr_vld: got a=%0h b=%0h want a=1 b=0", bus0.a_rd_vld, bus0.b_rd_vld); end
    n_cmp++; if (bus0.a_rd_data !== 72'h1234) begin n_fail++; $display("FAIL sr_data: got %0h want 1234", bus0.a_rd_data); end
    @(negedge clk); bus0.rd_0_vld = 0; #1;
    n_cmp++; if (out0 !== 4'd0) begin n_fail++; $display("FAIL sr_out0: got %0d want 0", out0); end
    n_cmp++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL sr_err: got %0h want 0", err0); end
  endtask

  task automatic test_push_pop();
    @(negedge clk); bus0.a_rd_addr = 19'h20; bus0.a_rd_req = 1;
    @(negedge clk); bus0.rd_0_ack = 1; #1;
    n_cmp++; if (bus0.a_rd_ack !== 1'b1) begin n_fail++; $display("FAIL pp_ack_a: got %0h want 1", bus0.a_rd_ack); end
    @(negedge clk); bus0.rd_0_ack = 0; bus0.a_rd_req = 0; bus0.b_rd_addr = 19'h21; bus0.b_rd_req = 1;
    @(negedge clk); bus0.rd_0_ack = 1; bus0.rd_0_vld = 1; bus0.rd_0_data = 72'h55; #1;
    n_cmp++; if (bus0.rd_0_addr !== 19'h21) begin n_fail++; $display("FAIL pp_addr_b: got %0h want 21", bus0.rd_0_addr); end
    n_cmp++; if (bus0.b_rd_ack !== 1'b1) begin n_fail++; $display("FAIL pp_ack_b: got %0h want 1", bus0.b_rd_ack); end
    n_cmp++; if (bus0.a_rd_vld !== 1'b1 || bus0.b_rd_vld !== 1'b0) begin n_fail++; $display("FAIL pp_vld_a: got a=%0h b=%0h want a=1 b=0", bus0.a_rd_vld, bus0.b_rd_vld); end
    @(negedge clk); bus0.rd_0_ack = 0; bus0.rd_0_vld = 0; bus0.b_rd_req = 0; #1;
    n_cmp++; if (out0 !== 4'd1) begin n_fail++; $display("FAIL pp_out: got %0d want 1", out0); end
    n_cmp++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL pp_err: got %0h want 0", err0); end
    @(negedge clk); bus0.rd_0_vld = 1; bus0.rd_0_data = 72'h66; #1;
    n_cmp++; if (bus0.b_rd_vld !== 1'b1 || bus0.a_rd_vld !== 1'b0) begin n_fail++; $display("FAIL pp_vld_b: got a=%0h b=%0h want a=0 b=1", bus0.a_rd_vld, bus0.b_rd_vld); end
    @(negedge clk); bus0.rd_0_vld = 0; #1;
    n_cmp++; if (out0 !== 4'd0) begin n_fail++; $display("FAIL pp_out0: got %0d want 0", out0); end
  endtask

  task automatic test_contention();
    logic exp_a;
    @(negedge clk); bus0.a_rd_addr = 19'h100; bus0.a_rd_req = 1; bus0.b_rd_addr = 19'h200; bus0.b_rd_req = 1;
    for (int i = 0; i < 8; i++) begin
      exp_a = (i % 2 == 0);
      @(negedge clk); bus0.rd_0_ack = 1; #1;
      n_cmp++; if (bus0.rd_0_req !== 1'b1) begin n_fail++; $display("FAIL ct_req[%0d]: got %0h want 1", i, bus0.rd_0_req); end
      n_cmp++; if (bus0.a_rd_ack !== exp_a || bus0.b_rd_ack !== !exp_a) begin n_fail++; $display("FAIL ct_owner[%0d]: got a=%0h b=%0h want a=%0h", i, bus0.a_rd_ack, bus0.b_rd_ack, exp_a); end
      n_cmp++; if (bus0.rd_0_addr !== (exp_a ? 19'h100 : 19'h200)) begin n_fail++; $display("FAIL ct_addr[%0d]: got %0h want %0h", i, bus0.rd_0_addr, exp_a ? 19'h100 : 19'h200); end
      @(negedge clk); bus0.rd_0_ack = 0;
      if (i == 7) begin bus0.a_rd_req = 0; bus0.b_rd_req = 0; end
      #1;
      n_cmp++; if (bus0.rd_0_req !== 1'b0) begin n_fail++; $display("FAIL ct_gap[%0d]: got %0h want 0", i, bus0.rd_0_req); end
    end
    n_cmp++; if (out0 !== 4'd8) begin n_fail++; $display("FAIL ct_out: got %0d want 8", out0); end
  endtask

  task automatic test_tag_full();
    logic exp_b;
    @(negedge clk); bus0.a_rd_addr = 19'h300; bus0.a_rd_req = 1; #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus0.rd_0_req !== 1'b0) begin n_fail++; $display("FAIL tf_blocked[%0d]: got %0h want 0", i, bus0.rd_0_req); end
      @(negedge clk); #1;
    end
    bus0.rd_0_vld = 1; bus0.rd_0_data = 72'hA0; #1;
    n_cmp++; if (bus0.a_rd_vld !== 1'b1 || bus0.b_rd_vld !== 1'b0) begin n_fail++; $display("FAIL tf_pop_vld: got a=%0h b=%0h want a=1 b=0", bus0.a_rd_vld, bus0.b_rd_vld); end
    @(negedge clk); bus0.rd_0_vld = 0; #1;
    n_cmp++; if (bus0.rd_0_req !== 1'b0) begin n_fail++; $display("FAIL tf_grant_cycle: got %0h want 0", bus0.rd_0_req); end
    n_cmp++; if (out0 !== 4'd7) begin n_fail++; $display("FAIL tf_out7: got %0d want 7", out0); end
    @(negedge clk); bus0.rd_0_ack = 1; #1;
    n_cmp++; if (bus0.rd_0_req !== 1'b1 || bus0.rd_0_addr !== 19'h300) begin n_fail++; $display("FAIL tf_issue: got req=%0h addr=%0h want req=1 addr=300", bus0.rd_0_req, bus0.rd_0_addr); end
    n_cmp++; if (bus0.a_rd_ack !== 1'b1) begin n_fail++; $display("FAIL tf_ack: got %0h want 1", bus0.a_rd_ack); end
    @(negedge clk); bus0.rd_0_ack = 0; bus0.a_rd_req = 0; #1;
    n_cmp++; if (out0 !== 4'd8) begin n_fail++; $display("FAIL tf_out8: got %0d want 8", out0); end
    for (int i = 0; i < 8; i++) begin
      exp_b = (i % 2 == 0);
      @(negedge clk); bus0.rd_0_vld = 1; bus0.rd_0_data = 72'hB0 + 72'(i); #1;
      n_cmp++; if (bus0.b_rd_vld !== exp_b || bus0.a_rd_vld !== !exp_b) begin n_fail++; $display("FAIL tf_drain_vld[%0d]: got a=%0h b=%0h want b=%0h", i, bus0.a_rd_vld, bus0.b_rd_vld, exp_b); end
      n_cmp++; if (bus0.b_rd_data !== 72'hB0 + 72'(i)) begin n_fail++; $display("FAIL tf_drain_data[%0d]: got %0h want %0h", i, bus0.b_rd_data, 72'hB0 + 72'(i)); end
    end
    @(negedge clk); bus0.rd_0_vld = 0; #1;
    n_cmp++; if (out0 !== 4'd0 || err0 !== 1'b0) begin n_fail++; $display("FAIL tf_drained: got out=%0d err=%0h want out=0 err=0", out0, err0); end
  endtask

  task automatic test_prio();
    @(negedge clk); bus1.a_rd_addr = 19'h1A; bus1.a_rd_req = 1; bus1.b_rd_addr = 19'h1B; bus1.b_rd_req = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus1.rd_0_ack = 1; #1;
      n_cmp++; if (bus1.b_rd_ack !== 1'b1 || bus1.a_rd_ack !== 1'b0) begin n_fail++; $display("FAIL pr_b[%0d]: got a=%0h b=%0h want a=0 b=1", i, bus1.a_rd_ack, bus1.b_rd_ack); end
      @(negedge clk); bus1.rd_0_ack = 0;
      if (i == 2) bus1.b_rd_req = 0;
    end
    @(negedge clk); bus1.rd_0_ack = 1; #1;
    n_cmp++; if (bus1.a_rd_ack !== 1'b1 || bus1.b_rd_ack !== 1'b0) begin n_fail++; $display("FAIL pr_a: got a=%0h b=%0h want a=1 b=0", bus1.a_rd_ack, bus1.b_rd_ack); end
    n_cmp++; if (bus1.rd_0_addr !== 19'h1A) begin n_fail++; $display("FAIL pr_addr: got %0h want 1a", bus1.rd_0_addr); end
    @(negedge clk); bus1.rd_0_ack = 0; bus1.a_rd_req = 0; #1;
    n_cmp++; if (out1 !== 4'd4) begin n_fail++; $display("FAIL pr_out: got %0d want 4", out1); end
  endtask

  task automatic test_writes();
    @(negedge clk);
    bus0.a_wr_addr = 19'h5; bus0.a_wr_data = 72'hAA; bus0.a_wr_req = 1;
    bus0.b_wr_addr = 19'h6; bus0.b_wr_data = 72'hBB; bus0.b_wr_req = 1; #1;
    n_cmp++; if (bus0.wr_0_req !== 1'b0) begin n_fail++; $display("FAIL wr_pre: got %0h want 0", bus0.wr_0_req); end
    @(negedge clk); #1;
    n_cmp++; if (bus0.wr_0_req !== 1'b1 || bus0.wr_0_addr !== 19'h5 || bus0.wr_0_data !== 72'hAA) begin n_fail++; $display("FAIL wr_a_issue: got req=%0h addr=%0h data=%0h want 1/5/aa", bus0.wr_0_req, bus0.wr_0_addr, bus0.wr_0_data); end
    n_cmp++; if (bus0.a_wr_ack !== 1'b0) begin n_fail++; $display("FAIL wr_a_early: got %0h want 0", bus0.a_wr_ack); end
    @(negedge clk); bus0.wr_0_ack = 1; #1;
    n_cmp++; if (bus0.wr_0_data !== 72'hAA) begin n_fail++; $display("FAIL wr_a_hold: got %0h want aa", bus0.wr_0_data); end
    n_cmp++; if (bus0.a_wr_ack !== 1'b1 || bus0.b_wr_ack !== 1'b0) begin n_fail++; $display("FAIL wr_a_ack: got a=%0h b=%0h want a=1 b=0", bus0.a_wr_ack, bus0.b_wr_ack); end
    @(negedge clk); bus0.wr_0_ack = 0; bus0.a_wr_req = 0; #1;
    n_cmp++; if (bus0.wr_0_req !== 1'b0 || bus0.a_wr_ack !== 1'b0) begin n_fail++; $display("FAIL wr_gap: got req=%0h ack=%0h want 0/0", bus0.wr_0_req, bus0.a_wr_ack); end
    @(negedge clk); #1;
    n_cmp++; if (bus0.wr_0_req !== 1'b1 || bus0.wr_0_addr !== 19'h6 || bus0.wr_0_data !== 72'hBB) begin n_fail++; $display("FAIL wr_b_issue: got req=%0h addr=%0h data=%0h want 1/6/bb", bus0.wr_0_req, bus0.wr_0_addr, bus0.wr_0_data); end
    @(negedge clk); bus0.wr_0_ack = 1; #1;
    n_cmp++; if (bus0.b_wr_ack !== 1'b1 || bus0.a_wr_ack !== 1'b0) begin n_fail++; $display("FAIL wr_b_ack: got a=%0h b=%0h want a=0 b=1", bus0.a_wr_ack, bus0.b_wr_ack); end
    @(negedge clk); bus0.wr_0_ack = 0; bus0.b_wr_req = 0; #1;
    n_cmp++; if (bus0.wr_0_req !== 1'b0 || bus0.b_wr_ack !== 1'b0) begin n_fail++; $display("FAIL wr_done: got req=%0h ack=%0h want 0/0", bus0.wr_0_req, bus0.b_wr_ack); end
    @(negedge clk); #1;
    n_cmp++; if (bus0.wr_0_req !== 1'b0) begin n_fail++; $display("FAIL wr_idle: got %0h want 0", bus0.wr_0_req); end
  endtask

  task automatic test_spurious_and_reset();
    @(negedge clk); bus0.rd_0_vld = 1; bus0.rd_0_data = 72'hDEAD; #1;
    n_cmp++; if (bus0.a_rd_vld !== 1'b0 || bus0.b_rd_vld !== 1'b0) begin n_fail++; $display("FAIL sp_vld: got a=%0h b=%0h want 0/0", bus0.a_rd_vld, bus0.b_rd_vld); end
    @(negedge clk); bus0.rd_0_vld = 0; #1;
    n_cmp++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL sp_err: got %0h want 1", err0); end
    n_cmp++; if (out0 !== 4'd0) begin n_fail++; $display("FAIL sp_out: got %0d want 0", out0); end
    @(negedge clk); bus0.a_rd_addr = 19'h40; bus0.a_rd_req = 1;
    @(negedge clk); bus0.rd_0_ack = 1; #1;
    n_cmp++; if (bus0.a_rd_ack !== 1'b1) begin n_fail++; $display("FAIL rb_first_ack: got %0h want 1", bus0.a_rd_ack); end
    @(negedge clk); bus0.rd_0_ack = 0; bus0.a_wr_addr = 19'h7; bus0.a_wr_data = 72'hCC; bus0.a_wr_req = 1;
    @(negedge clk); #1;
    n_cmp++; if (bus0.rd_0_req !== 1'b1 || bus0.wr_0_req !== 1'b1 || out0 !== 4'd1) begin n_fail++; $display("FAIL rb_busy: got rd=%0h wr=%0h out=%0d want 1/1/1", bus0.rd_0_req, bus0.wr_0_req, out0); end
    reset = 1'b0; bus0.rd_0_ack = 1; bus0.wr_0_ack = 1; #1;
    n_cmp++; if (bus0.rd_0_req !== 1'b0 || bus0.wr_0_req !== 1'b0) begin n_fail++; $display("FAIL rb_req: got rd=%0h wr=%0h want 0/0", bus0.rd_0_req, bus0.wr_0_req); end
    n_cmp++; if (bus0.a_rd_ack !== 1'b0 || bus0.a_wr_ack !== 1'b0) begin n_fail++; $display("FAIL rb_ack: got rd=%0h wr=%0h want 0/0", bus0.a_rd_ack, bus0.a_wr_ack); end
    n_cmp++; if (out0 !== 4'd0 || err0 !== 1'b0) begin n_fail++; $display("FAIL rb_status: got out=%0d err=%0h want 0/0", out0, err0); end
    n_cmp++; if (bus0.rd_0_addr !== 19'h0 || bus0.wr_0_data !== 72'h0) begin n_fail++; $display("FAIL rb_bus: got addr=%0h data=%0h want 0/0", bus0.rd_0_addr, bus0.wr_0_data); end
    @(negedge clk); clear_inputs();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus0.rd_0_req !== 1'b0 || err0 !== 1'b0) begin n_fail++; $display("FAIL rb_after: got req=%0h err=%0h want 0/0", bus0.rd_0_req, err0); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_push_pop();
    test_contention();
    test_tag_full();
    test_prio();
    test_writes();
    test_spurious_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
